// File: rtl/cpu_pkg.sv
// Shared definitions for the slice CPU: instruction format, opcodes and fetch FSM states.
// The HALT state exists only when IFU_HALT_AT_END_EN is defined.
package cpu_pkg;

  localparam int unsigned INSTR_W = 9;

  localparam int unsigned OPCODE_MSB = 8;
  localparam int unsigned OPCODE_LSB = 6;
  localparam int unsigned RD_MSB     = 5;
  localparam int unsigned RD_LSB     = 4;
  localparam int unsigned RS1_MSB    = 3;
  localparam int unsigned RS1_LSB    = 2;
  localparam int unsigned RS2_MSB    = 1;
  localparam int unsigned RS2_LSB    = 0;

  localparam logic [2:0] ADD    = 3'b000;
  localparam logic [2:0] POPCNT = 3'b010;
  localparam logic [2:0] CMP    = 3'b011;

  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
  } instr_t;

  typedef enum logic [1:0] {
    StIdle,
`ifdef IFU_HALT_AT_END_EN
    StHalt,
`endif
    StRun
  } ifu_state_e;

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter: redirect has priority over the sequential increment, which wraps at 2^PC_W.
module ifu_pc_reg #(
  parameter int unsigned     PC_W     = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (load) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: ROM addressing, output register and valid/ready handshake to decode.
// Define IFU_HALT_AT_END_EN to stop fetching after the last ROM address is loaded.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [PC_W-1:0]    pc_addr,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               halted
);

  ifu_state_e      state_d, state_q;
  logic            load;
  logic [PC_W-1:0] pc;

  logic            out_valid_d, out_valid_q;
  instr_t          out_instr_d, out_instr_q;
  logic [PC_W-1:0] out_pc_d, out_pc_q;

  // Entering RUN and loading happen on the same edge.
  assign load = ((state_q == StRun) || ((state_q == StIdle) && en)) && en &&
                (!out_valid_q || out_ready) && !redirect_valid;

  ifu_pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .rst            (rst),
    .load           (load),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (en) state_d = StRun;
      StRun:  if (!en) state_d = StIdle;
`ifdef IFU_HALT_AT_END_EN
      StHalt: if (redirect_valid) state_d = en ? StRun : StIdle;
`endif
      default: state_d = StIdle;
    endcase
`ifdef IFU_HALT_AT_END_EN
    if (load && (&pc)) state_d = StHalt;
`endif
  end

  always_comb begin
`ifdef IFU_HALT_AT_END_EN
    halted = (state_q == StHalt);
`else
    halted = 1'b0;
`endif
  end

  // A redirect flushes; a handshake with ready high in the same cycle still counts as accepted.
  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    if (redirect_valid) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d = 1'b1;
      out_instr_d = instr_t'(instr_in);
      out_pc_d    = pc;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign pc_addr   = pc;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: cycle vector table, transfer scoreboard and
// hand-written wrap/halt and asynchronous-reset sequences.
module tb_instr_fetch_unit;

  localparam int unsigned PC_W = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [PC_W-1:0] pc_addr;
  logic [8:0]      instr_in;
  logic            out_valid;
  logic            out_ready;
  logic [8:0]      out_instr;
  logic [PC_W-1:0] out_pc;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            halted;

  logic [8:0] rom [16];

  always #5 clk = ~clk;

  assign instr_in = rom[pc_addr];

  instr_fetch_unit #(
    .PC_W     (PC_W),
    .RESET_PC (4'd0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .pc_addr        (pc_addr),
    .instr_in       (instr_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  typedef struct {
    logic       en;
    logic       rdy;
    logic       rv;
    logic [3:0] rpc;
    logic       ld;
    logic       ev;
    logic [3:0] epc;
    logic [8:0] einstr;
    logic [3:0] eaddr;
  } vec_t;

  typedef struct {
    logic [3:0] pc;
    logic [8:0] instr;
  } xfer_t;

  vec_t  vecs [16];
  xfer_t sb_q [$];
  int    n_checks = 0;
  int    n_fail   = 0;

  function automatic vec_t mk(input int en_, input int rdy_, input int rv_, input int rpc_,
                              input int ld_, input int ev_, input int epc_, input int ei_,
                              input int ea_);
    vec_t v;
    v.en     = en_[0];
    v.rdy    = rdy_[0];
    v.rv     = rv_[0];
    v.rpc    = rpc_[3:0];
    v.ld     = ld_[0];
    v.ev     = ev_[0];
    v.epc    = epc_[3:0];
    v.einstr = ei_[8:0];
    v.eaddr  = ea_[3:0];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] pc, input logic [8:0] instr);
    xfer_t e;
    e.pc    = pc;
    e.instr = instr;
    sb_q.push_back(e);
  endtask

  // Pops the scoreboard on every handshake, then advances to just after the next edge.
  task automatic step();
    xfer_t e;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL xfer_unexpected: got out_pc 0x%0h, expected no transfer", out_pc);
      end else begin
        e = sb_q.pop_front();
        check("xfer_pc", 32'(out_pc), 32'(e.pc));
        check("xfer_instr", 32'(out_instr), 32'(e.instr));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en_v, input logic rdy_v, input logic rv_v,
                       input logic [3:0] rpc_v);
    en             = en_v;
    out_ready      = rdy_v;
    redirect_valid = rv_v;
    redirect_pc    = rpc_v;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 9'h000;
    rom[0] = 9'h000;
    rom[1] = 9'h015;
    rom[2] = 9'h021;
    rom[3] = 9'h0B8;
    rom[4] = 9'h0CB;

    //               en rdy rv rpc ld ev pc instr  addr
    vecs[0]  = mk(1, 1, 0, 0, 1, 1, 0, 'h000, 1);
    vecs[1]  = mk(1, 1, 0, 0, 1, 1, 1, 'h015, 2);
    vecs[2]  = mk(1, 1, 0, 0, 1, 1, 2, 'h021, 3);
    vecs[3]  = mk(1, 0, 0, 0, 0, 1, 2, 'h021, 3);
    vecs[4]  = mk(1, 0, 0, 0, 0, 1, 2, 'h021, 3);
    vecs[5]  = mk(1, 0, 0, 0, 0, 1, 2, 'h021, 3);
    vecs[6]  = mk(1, 1, 0, 0, 1, 1, 3, 'h0B8, 4);
    vecs[7]  = mk(1, 1, 1, 1, 0, 0, 0, 'h000, 1);
    vecs[8]  = mk(1, 1, 0, 0, 1, 1, 1, 'h015, 2);
    vecs[9]  = mk(1, 1, 0, 0, 1, 1, 2, 'h021, 3);
    vecs[10] = mk(0, 0, 0, 0, 0, 1, 2, 'h021, 3);
    vecs[11] = mk(0, 0, 0, 0, 0, 1, 2, 'h021, 3);
    vecs[12] = mk(0, 1, 0, 0, 0, 0, 0, 'h000, 3);
    vecs[13] = mk(0, 1, 0, 0, 0, 0, 0, 'h000, 3);
    vecs[14] = mk(1, 1, 0, 0, 1, 1, 3, 'h0B8, 4);
    vecs[15] = mk(1, 1, 0, 0, 1, 1, 4, 'h0CB, 5);

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    check("rst_pc_addr", 32'(pc_addr), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_instr", 32'(out_instr), 32'd0);
    check("rst_out_pc", 32'(out_pc), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].en, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
      if (vecs[i].ld) push(vecs[i].epc, vecs[i].einstr);
      step();
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      check($sformatf("v%0d_pc_addr", i), 32'(pc_addr), 32'(vecs[i].eaddr));
      check($sformatf("v%0d_halted", i), 32'(halted), 32'd0);
      if (vecs[i].ev) begin
        check($sformatf("v%0d_out_pc", i), 32'(out_pc), 32'(vecs[i].epc));
        check($sformatf("v%0d_instr", i), 32'(out_instr), 32'(vecs[i].einstr));
      end
    end

    // Run to the last ROM address.
    drive(1'b1, 1'b1, 1'b1, 4'd14);
    step();
    check("end_redir_valid", 32'(out_valid), 32'd0);
    check("end_redir_addr", 32'(pc_addr), 32'd14);
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    push(4'd14, 9'h000);
    step();
    check("end_pc14", 32'(out_pc), 32'd14);
    push(4'd15, 9'h000);
    step();
    check("end_pc15_valid", 32'(out_valid), 32'd1);
    check("end_pc15", 32'(out_pc), 32'd15);
    check("end_addr_wrap", 32'(pc_addr), 32'd0);
`ifndef IFU_HALT_AT_END_EN
    check("wrap_halted", 32'(halted), 32'd0);
    push(4'd0, 9'h000);
    step();
    check("wrap_valid", 32'(out_valid), 32'd1);
    check("wrap_out_pc", 32'(out_pc), 32'd0);
    check("wrap_instr", 32'(out_instr), 32'd0);
    check("wrap_addr", 32'(pc_addr), 32'd1);
`else
    check("halt_halted", 32'(halted), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("halt%0d_valid", k), 32'(out_valid), 32'd0);
      check($sformatf("halt%0d_halted", k), 32'(halted), 32'd1);
      check($sformatf("halt%0d_addr", k), 32'(pc_addr), 32'd0);
    end
    drive(1'b1, 1'b1, 1'b1, 4'd4);
    step();
    check("resume_valid", 32'(out_valid), 32'd0);
    check("resume_halted", 32'(halted), 32'd0);
    check("resume_addr", 32'(pc_addr), 32'd4);
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    push(4'd4, 9'h0CB);
    step();
    check("resume_out_pc", 32'(out_pc), 32'd4);
    check("resume_instr", 32'(out_instr), 32'h0CB);
`endif

    // Asynchronous reset while stalled.
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    step();
    check("stall_valid", 32'(out_valid), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_pc_addr", 32'(pc_addr), 32'd0);
    check("arst_out_pc", 32'(out_pc), 32'd0);
    check("arst_halted", 32'(halted), 32'd0);
    sb_q.delete();
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    step();
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("post_rst_addr", 32'(pc_addr), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    push(4'd0, 9'h000);
    step();
    check("post_rst_load", 32'(out_valid), 32'd1);
    check("post_rst_out_pc", 32'(out_pc), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    step();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
